mdu_iter: RTL

- Parametrised, iterative multiply/divide unit implementing the RV32M operations. It is the sequential companion of the single-cycle integer ALU.
- Sits in the EX stage beside the ALU. The decoder steers M-extension ops here. The pipeline stalls on a valid/ready handshake until the result is accepted.
- Performs one shift-add or shift-subtract step per cycle, on magnitudes, with sign correction applied at the end.

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_step.sv | 38 +++
 rtl/mdu_iter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// op_sel encodings, FSM state type and two's-complement helpers.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  // Helpers work on a fixed wide word; callers extend in and size-cast out.
  localparam int unsigned MDU_FN_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  function automatic logic [MDU_FN_W-1:0] mdu_abs(input logic [MDU_FN_W-1:0] v);
    return v[MDU_FN_W-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [MDU_FN_W-1:0] mdu_cneg(input logic [MDU_FN_W-1:0] v,
                                                   input logic              neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath: shift-add for multiply,
// restoring trial-subtract for divide. Purely combinational.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   rem_in,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] acc_out,
  output logic [XLEN-1:0]   rem_out
);

  logic [XLEN-1:0] addend;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic            qbit;

  always_comb begin
    addend  = acc_in[0] ? opb : '0;
    sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, addend};
    // Remainder is always < divisor, so the shifted value fits in XLEN+1 bits
    shifted = {rem_in, acc_in[XLEN-1]};
    trial   = shifted - {1'b0, opb};
    qbit    = ~trial[XLEN];
    if (is_div) begin
      acc_out = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-2:0], qbit};
      rem_out = qbit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    end else begin
      acc_out = {sum, acc_in[XLEN-1:1]};
      rem_out = rem_in;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: FSM, counter, operand registers and
// valid/ready handshake. Optional early-out: define MDU_ZERO_EARLY_OUT_EN.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_sel,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic            flush_in,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_out,
  output logic            busy_out
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned W2    = 2 * XLEN;
  localparam int unsigned PADW  = MDU_FN_W - XLEN;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [W2-1:0]    acc_q, step_acc;
  logic [XLEN-1:0]  rem_q, step_rem;
  logic [XLEN-1:0]  opb_q;
  logic             is_div_q, is_rem_q, sel_hi_q, neg_quo_q, neg_rem_q;

  logic             op_div, a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic             div0, ovf, early, special;
  logic [XLEN-1:0]  early_res, special_res;
  logic             accept, step_en, last;

  logic [W2-1:0]    prod_fix;
  logic [XLEN-1:0]  quo_fix, rem_fix, final_res;

  // Operand decode on the request, used only at the accept edge
  always_comb begin
    op_div   = op_sel[2];
    a_signed = (op_sel == MDU_MUL) || (op_sel == MDU_MULH) || (op_sel == MDU_MULHSU) ||
               (op_sel == MDU_DIV) || (op_sel == MDU_REM);
    b_signed = (op_sel == MDU_MUL) || (op_sel == MDU_MULH) ||
               (op_sel == MDU_DIV) || (op_sel == MDU_REM);
    sign_a   = a_signed & rs1_in[XLEN-1];
    sign_b   = b_signed & rs2_in[XLEN-1];
    mag_a    = XLEN'(mdu_abs({{PADW{sign_a}}, rs1_in}));
    mag_b    = XLEN'(mdu_abs({{PADW{sign_b}}, rs2_in}));
    div0     = op_div && (rs2_in == '0);
    ovf      = ((op_sel == MDU_DIV) || (op_sel == MDU_REM)) &&
               (rs1_in == MOST_NEG) && (rs2_in == '1);
`ifdef MDU_ZERO_EARLY_OUT_EN
    if (op_div) begin
      early     = mag_a < mag_b;
      early_res = op_sel[1] ? rs1_in : '0;
    end else begin
      early     = (rs1_in == '0) || (rs2_in == '0);
      early_res = '0;
    end
`else
    early     = 1'b0;
    early_res = '0;
`endif
    special = div0 || ovf || early;
    if (div0)
      special_res = op_sel[1] ? rs1_in : '1;
    else if (ovf)
      special_res = op_sel[1] ? '0 : rs1_in;
    else
      special_res = early_res;
  end

  mdu_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_div_q),
    .acc_in  (acc_q),
    .rem_in  (rem_q),
    .opb     (opb_q),
    .acc_out (step_acc),
    .rem_out (step_rem)
  );

  // Sign correction is applied to the final step's output directly
  always_comb begin
    prod_fix = W2'(mdu_cneg(MDU_FN_W'(step_acc), neg_quo_q));
    quo_fix  = XLEN'(mdu_cneg(MDU_FN_W'(step_acc[XLEN-1:0]), neg_quo_q));
    rem_fix  = XLEN'(mdu_cneg(MDU_FN_W'(step_rem), neg_rem_q));
    if (is_div_q)
      final_res = is_rem_q ? rem_fix : quo_fix;
    else
      final_res = sel_hi_q ? prod_fix[W2-1:XLEN] : prod_fix[XLEN-1:0];
  end

  assign last = (cnt_q == CNT_W'(XLEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (op_valid && !flush_in) begin
          accept  = 1'b1;
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush_in) begin
          state_d = IDLE;
        end else begin
          step_en = 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        if (flush_in || res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      sel_hi_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_out   <= '0;
    end else begin
      if (accept) begin
        cnt_q     <= '0;
        acc_q     <= {{XLEN{1'b0}}, (op_div ? mag_a : mag_b)};
        rem_q     <= '0;
        opb_q     <= op_div ? mag_b : mag_a;
        is_div_q  <= op_div;
        is_rem_q  <= op_sel[1];
        sel_hi_q  <= (op_sel != MDU_MUL);
        neg_quo_q <= sign_a ^ sign_b;
        neg_rem_q <= sign_a;
        if (special) res_out <= special_res;
      end
      if (step_en) begin
        acc_q <= step_acc;
        rem_q <= step_rem;
        cnt_q <= cnt_q + 1'b1;
        if (last) res_out <= final_res;
      end
    end
  end

  assign op_ready  = (state_q == IDLE) && !rst;
  assign busy_out  = (state_q != IDLE);
  assign res_valid = (state_q == DONE);

endmodule
